gomoku_move_ctrl: RTL
=====================

// Module: gomoku_move_ctrl
// PURPOSE
// - Game sequencer that owns the 16x16 Gomoku board register and drives the renderer's board/status/pointer inputs.
// - Takes single-cycle move/place pulses, moves the pointer and places stones for alternating players.
// - After each placement, walks the board one cell per cycle to detect WIN_LEN in a row.
// - Sits between the debounced key/switch logic and the VGA renderer.
// PARAMETERS
// - BOARD_N   16  cells per side; x/y width = $clog2(BOARD_N)
// - WIN_LEN   5   consecutive same-colour stones that win
// PORTS
// - Clck           in   1    system clock (50 MHz)
// - Reset          in   1    asynchronous, active-low reset
// - mv_up          in   1    1-cycle pulse: y-1
// - mv_down        in   1    1-cycle pulse: y+1
// - mv_left        in   1    1-cycle pulse: x-1
// - mv_right       in   1    1-cycle pulse: x+1
// - place          in   1    1-cycle pulse: put current player's stone at pointer
// - board          out  512  cell(x,y) at bits [x*2 + y*32 +: 2]
// - gaming_status  out  2    00 black to move, 01 white to move, 10 black won, 11 white won
// - pointer_loc_x  out  4    pointer column
// - pointer_loc_y  out  4    pointer row
// - busy           out  1    win check in progress
// - illegal        out  1    1-cycle pulse: place rejected
// - draw           out  1    board full, no winner
// BEHAVIOUR
// - Cell codes: 00 empty, 01 black, 10 white, 11 never written.
// - Reset (async assert, sync release): board=0, status=00, pointer=(7,7), busy=0, illegal=0, draw=0, FSM=PLAY.
// - FSM states: PLAY, CHECK, DONE.
// - PLAY, pointer:
//   - Each axis saturates at 0 and BOARD_N-1; no wrap.
//   - Left+right in the same cycle: x unchanged. Up+down: y unchanged.
//   - x and y may both update in one cycle.
// - PLAY, place:
//   - Place has priority over move pulses in the same cycle; those moves are dropped.
//   - Target cell non-empty: illegal=1 next cycle, no other change.
//   - Target cell empty: write current colour next cycle; latch (px,py,colour); busy=1; go to CHECK.
//   - A 9-bit move counter increments on each legal place.
// - CHECK:
//   - All inputs ignored; pointer frozen.
//   - Directions in order: H(1,0), V(0,1), D(1,1), A(1,-1).
//   - Per direction, walk +dir up to WIN_LEN-1 steps, then -dir up to WIN_LEN-1 steps, one cell read per cycle.
//   - A walk stops early at the board edge or on a non-matching cell.
//   - run = 1 + pos + neg (4-bit). run >= WIN_LEN -> win; remaining directions are skipped.
//   - Worst-case latency: 4*2*(WIN_LEN-1)=32 cycles plus 1 exit cycle.
// - CHECK exit:
//   - Win: status = 10 (black) or 11 (white); go to DONE.
//   - No win and counter==BOARD_N*BOARD_N: draw=1; go to DONE.
//   - Otherwise: toggle status 00<->01; go to PLAY.
//   - busy drops in the same cycle the status updates.
// - DONE: all inputs ignored; board, status and pointer hold until Reset.
// - Reset mid-CHECK: aborts the check; everything returns to reset values.
// - board is a plain register; readers sample it any cycle (CDC to VGA is the renderer's job).
// STRUCTURE
// - Shared package gomoku_pkg:
//   - cell codes (CELL_EMPTY/BLACK/WHITE)
//   - status codes (ST_BLACK_TURN, ST_WHITE_TURN, ST_BLACK_WON, ST_WHITE_WON)
//   - BOARD_N, WIN_LEN defaults
//   - function cell_off(x,y) = x*2 + y*BOARD_N*2
// - Sub-module gomoku_line_scan: the direction/step walker.
//   - In: start pulse, origin, colour, board.
//   - Out: done, win.
//   - Parent owns the PLAY/DONE FSM, pointer, board writes and move counter.
// TESTING
// - Reset -> board=0, status=00, pointer=(7,7); 3 mv_left pulses -> x=4.
// - Pointer (0,0); mv_left and mv_up -> stays (0,0). mv_left+mv_right together -> x unchanged.
// - place at (7,7), then place again at (7,7) -> cell=01, status=01, then illegal pulse, status stays 01.
// - Black at (3..7,5), white elsewhere off-line -> after 5th black, busy<=33 cycles, status=10; later pulses ignored.
// - Anti-diagonal white (10,2),(9,3),(8,4),(7,5),(6,6), last placed in the middle -> status=11.
// - Assert Reset during CHECK -> board=0, busy=0, status=00 immediately. Fill 256 cells with no five -> draw=1.

Source files
------------

// File: rtl/gomoku_pkg.sv
// Shared board geometry, cell/status encodings and the cell offset helper
// used by the Gomoku sequencer and its line scanner.
package gomoku_pkg;

  localparam int BOARD_N = 16;
  localparam int WIN_LEN = 5;
  localparam int XW      = $clog2(BOARD_N);
  localparam int OFF_W   = $clog2(BOARD_N * BOARD_N * 2);

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  localparam logic [1:0] ST_BLACK_TURN = 2'b00;
  localparam logic [1:0] ST_WHITE_TURN = 2'b01;
  localparam logic [1:0] ST_BLACK_WON  = 2'b10;
  localparam logic [1:0] ST_WHITE_WON  = 2'b11;

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bit offset of cell (x,y) in the flat board vector: x*2 + y*BOARD_N*2.
  function automatic logic [OFF_W-1:0] cell_off(input logic [XW-1:0] x,
                                                input logic [XW-1:0] y);
    logic [OFF_W-1:0] xo;
    logic [OFF_W-1:0] yo;
    xo = OFF_W'(x);
    yo = OFF_W'(y);
    return (xo << 1) + yo * OFF_W'(BOARD_N * 2);
  endfunction

endpackage

// File: rtl/gomoku_line_scan.sv
// Line walker: after a stone lands, visits neighbours one cell per cycle in
// the H, V, D, A directions (each +dir then -dir, at most WIN_LEN-1 steps per
// side) and reports whether the placed stone completes WIN_LEN in a row.
// The origin cell itself is never read; it is counted as the leading 1.
module gomoku_line_scan
  import gomoku_pkg::*;
(
  input  logic                          Clck,
  input  logic                          Reset,
  input  logic                          start,
  input  logic [XW-1:0]                 org_x,
  input  logic [XW-1:0]                 org_y,
  input  logic [1:0]                    colour,
  input  logic [BOARD_N*BOARD_N*2-1:0]  board,
  output logic                          done,
  output logic                          win
);

  localparam int SW = $clog2(WIN_LEN);
  localparam int RW = 4;
  localparam int CW = XW + 2;
  localparam logic [SW-1:0]        STEP_MAX = SW'(WIN_LEN - 1);
  localparam logic [RW-1:0]        WIN_RUN  = RW'(WIN_LEN);
  localparam logic signed [CW-1:0] LIM      = CW'(BOARD_N);

  logic              active;
  logic              neg;
  logic [1:0]        dir;
  logic [SW-1:0]     step;
  logic [RW-1:0]     pos_cnt;
  logic [RW-1:0]     neg_cnt;
  logic [XW-1:0]     ox;
  logic [XW-1:0]     oy;
  logic [1:0]        col;

  logic signed [CW-1:0] dx;
  logic signed [CW-1:0] dy;
  logic signed [CW-1:0] st_s;
  logic signed [CW-1:0] cx;
  logic signed [CW-1:0] cy;
  logic                 in_bounds;
  logic                 hit;
  logic                 last_step;
  logic [OFF_W-1:0]     rd_off;
  logic [RW-1:0]        pos_nxt;
  logic [RW-1:0]        neg_nxt;
  logic [RW-1:0]        run;

  // Address of the cell under test and whether it extends the current run.
  always_comb begin
    dx = '0;
    dy = '0;
    case (dir)
      2'd0: dx = CW'(1);
      2'd1: dy = CW'(1);
      2'd2: begin dx = CW'(1); dy = CW'(1); end
      default: begin dx = CW'(1); dy = '1; end
    endcase
    if (neg) begin
      dx = -dx;
      dy = -dy;
    end
    st_s      = $signed({{(CW-SW){1'b0}}, step});
    cx        = $signed({2'b00, ox}) + dx * st_s;
    cy        = $signed({2'b00, oy}) + dy * st_s;
    in_bounds = !cx[CW-1] && (cx < LIM) && !cy[CW-1] && (cy < LIM);
    rd_off    = cell_off(cx[XW-1:0], cy[XW-1:0]);
    hit       = in_bounds && (board[rd_off +: 2] == col);
    last_step = !hit || (step == STEP_MAX);
    pos_nxt   = pos_cnt + RW'(hit && !neg);
    neg_nxt   = neg_cnt + RW'(hit && neg);
    run       = RW'(1) + pos_nxt + neg_nxt;
  end

  // Walk sequencing: step along one side, flip side, then judge the direction.
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      active  <= 1'b0;
      neg     <= 1'b0;
      dir     <= 2'd0;
      step    <= '0;
      pos_cnt <= '0;
      neg_cnt <= '0;
      ox      <= '0;
      oy      <= '0;
      col     <= CELL_EMPTY;
      done    <= 1'b0;
      win     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active  <= 1'b1;
        ox      <= org_x;
        oy      <= org_y;
        col     <= colour;
        dir     <= 2'd0;
        neg     <= 1'b0;
        step    <= SW'(1);
        pos_cnt <= '0;
        neg_cnt <= '0;
        win     <= 1'b0;
      end else if (active) begin
        pos_cnt <= pos_nxt;
        neg_cnt <= neg_nxt;
        if (!last_step) begin
          step <= step + 1'b1;
        end else if (!neg) begin
          neg  <= 1'b1;
          step <= SW'(1);
        end else if (run >= WIN_RUN) begin
          active <= 1'b0;
          done   <= 1'b1;
          win    <= 1'b1;
        end else if (dir == 2'd3) begin
          active <= 1'b0;
          done   <= 1'b1;
          win    <= 1'b0;
        end else begin
          dir     <= dir + 1'b1;
          neg     <= 1'b0;
          step    <= SW'(1);
          pos_cnt <= '0;
          neg_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/gomoku_move_ctrl.sv
// Gomoku game sequencer: owns the board register, pointer and turn status,
// accepts debounced move/place pulses and runs a win check after each stone.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_PLAY  | accepting moves/places for the player named by gaming_status
//   S_CHECK | line scanner running; inputs ignored, pointer frozen, busy=1
//   S_DONE  | game over (win or draw); everything holds until Reset
module gomoku_move_ctrl
  import gomoku_pkg::*;
(
  input  logic                          Clck,
  input  logic                          Reset,
  input  logic                          mv_up,
  input  logic                          mv_down,
  input  logic                          mv_left,
  input  logic                          mv_right,
  input  logic                          place,
  output logic [BOARD_N*BOARD_N*2-1:0]  board,
  output logic [1:0]                    gaming_status,
  output logic [XW-1:0]                 pointer_loc_x,
  output logic [XW-1:0]                 pointer_loc_y,
  output logic                          busy,
  output logic                          illegal,
  output logic                          draw
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int MW    = $clog2(CELLS + 1);
  localparam logic [MW-1:0] FULL = MW'(CELLS);
  localparam logic [XW-1:0] XMAX = XW'(BOARD_N - 1);
  localparam logic [XW-1:0] HOME = XW'(BOARD_N / 2 - 1);

  state_t           state;
  logic [MW-1:0]    move_cnt;
  logic [1:0]       cur_colour;
  logic [OFF_W-1:0] tgt_off;
  logic             tgt_empty;
  logic             place_ok;
  logic             scan_done;
  logic             scan_win;

  assign cur_colour = gaming_status[0] ? CELL_WHITE : CELL_BLACK;
  assign tgt_off    = cell_off(pointer_loc_x, pointer_loc_y);
  assign tgt_empty  = (board[tgt_off +: 2] == CELL_EMPTY);
  // Scanner latches origin/colour on the same edge the stone is written.
  assign place_ok   = (state == S_PLAY) && place && tgt_empty;

  gomoku_line_scan u_scan (
    .Clck   (Clck),
    .Reset  (Reset),
    .start  (place_ok),
    .org_x  (pointer_loc_x),
    .org_y  (pointer_loc_y),
    .colour (cur_colour),
    .board  (board),
    .done   (scan_done),
    .win    (scan_win)
  );

  // Game FSM with registered board, pointer, status and flag outputs.
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      board         <= '0;
      gaming_status <= ST_BLACK_TURN;
      pointer_loc_x <= HOME;
      pointer_loc_y <= HOME;
      busy          <= 1'b0;
      illegal       <= 1'b0;
      draw          <= 1'b0;
      move_cnt      <= '0;
      state         <= S_PLAY;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_PLAY: begin
          if (place) begin
            if (tgt_empty) begin
              board[tgt_off +: 2] <= cur_colour;
              move_cnt            <= move_cnt + 1'b1;
              busy                <= 1'b1;
              state               <= S_CHECK;
            end else begin
              illegal <= 1'b1;
            end
          end else begin
            if (mv_left && !mv_right && (pointer_loc_x != '0))
              pointer_loc_x <= pointer_loc_x - 1'b1;
            else if (mv_right && !mv_left && (pointer_loc_x != XMAX))
              pointer_loc_x <= pointer_loc_x + 1'b1;
            if (mv_up && !mv_down && (pointer_loc_y != '0))
              pointer_loc_y <= pointer_loc_y - 1'b1;
            else if (mv_down && !mv_up && (pointer_loc_y != XMAX))
              pointer_loc_y <= pointer_loc_y + 1'b1;
          end
        end
        S_CHECK: begin
          if (scan_done) begin
            busy <= 1'b0;
            if (scan_win) begin
              gaming_status <= (gaming_status == ST_WHITE_TURN) ? ST_WHITE_WON : ST_BLACK_WON;
              state         <= S_DONE;
            end else if (move_cnt == FULL) begin
              draw  <= 1'b1;
              state <= S_DONE;
            end else begin
              gaming_status <= (gaming_status == ST_WHITE_TURN) ? ST_BLACK_TURN : ST_WHITE_TURN;
              state         <= S_PLAY;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
